// File: rtl/p2s_serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial serializer.
// Holds the state enum, counter-width helper and idle-level default.
package p2s_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam logic IDLE_LEVEL_DEF = 1'b0;

    // Bit-counter width; never below one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/p2s_bit_counter.sv
// Modulo-WIDTH bit counter for the serializer.
// Ports: clk, rst (sync, active-high), clr_i, load_i, en_i,
//        cnt_o (count), last_o (count==WIDTH-1), range_ok_o (count<WIDTH).
module p2s_bit_counter
    import p2s_serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o,
    output logic          range_ok_o
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            // Wrap rather than run past the last bit index.
            if (int'(cnt_q) >= WIDTH - 1) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign last_o     = (cnt_q == LAST);
    assign range_ok_o = (int'(cnt_q) < WIDTH);

endmodule

// File: rtl/p2s_serializer.sv
// Parallel-to-serial converter feeding a serial sequence detector.
// Ports: clk, rst (sync, active-high), din[WIDTH], load -> ready,
//        x (serial bit), x_valid, done (last bit), ovr (dropped load).
module p2s_serializer
    import p2s_serializer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done,
    output logic             ovr
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             x_q, x_d;
    logic             xv_q, xv_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;

    logic [CW-1:0]    cnt;
    logic             last;
    logic             range_ok;
    logic             cnt_clr;
    logic             cnt_en;
    logic             accept;

    p2s_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .load_i     (accept),
        .en_i       (cnt_en),
        .cnt_o      (cnt),
        .last_o     (last),
        .range_ok_o (range_ok)
    );

    // Ready only from registered state: no path from load.
    assign ready  = (state_q == ST_IDLE) ||
                    (state_q == ST_SHIFT && last);
    assign accept = load && ready;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        x_d     = x_q;
        xv_d    = xv_q;
        done_d  = 1'b0;
        ovr_d   = load && !ready;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        if (accept) begin
            // Remaining bits stay in sreg; first bit goes out now.
            state_d = ST_SHIFT;
            xv_d    = 1'b1;
            if (MSB_FIRST) begin
                x_d    = din[WIDTH-1];
                sreg_d = din << 1;
            end else begin
                x_d    = din[0];
                sreg_d = din >> 1;
            end
        end else if (state_q == ST_SHIFT && range_ok && !last) begin
            cnt_en = 1'b1;
            xv_d   = 1'b1;
            done_d = (int'(cnt) == WIDTH - 2);
            if (MSB_FIRST) begin
                x_d    = sreg_q[WIDTH-1];
                sreg_d = sreg_q << 1;
            end else begin
                x_d    = sreg_q[0];
                sreg_d = sreg_q >> 1;
            end
        end else begin
            // Word finished, idle, or count out of range.
            state_d = ST_IDLE;
            sreg_d  = '0;
            x_d     = IDLE_LEVEL;
            xv_d    = 1'b0;
            cnt_clr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            x_q     <= IDLE_LEVEL;
            xv_q    <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign x       = x_q;
    assign x_valid = xv_q;
    assign done    = done_q;
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_p2s_serializer.sv
// Self-checking bench for p2s_serializer (MSB-first and LSB-first).
// Queue model per instance plus directed literal expectations.
module tb_p2s_serializer;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] din;

    logic ready0, x0, xv0, done0, ovr0;
    logic ready1, x1, xv1, done1, ovr1;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    bit armed    = 1'b0;

    bit mq[2][$];
    bit mx[2];
    bit mv[2];
    bit md[2];
    bit mo[2];
    bit mr[2];

    bit cap[2][$];
    int dq[$];

    p2s_serializer #(
        .WIDTH      (8),
        .MSB_FIRST  (1'b1),
        .IDLE_LEVEL (1'b0)
    ) u_msb (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .load    (load),
        .ready   (ready0),
        .x       (x0),
        .x_valid (xv0),
        .done    (done0),
        .ovr     (ovr0)
    );

    p2s_serializer #(
        .WIDTH      (8),
        .MSB_FIRST  (1'b0),
        .IDLE_LEVEL (1'b0)
    ) u_lsb (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .load    (load),
        .ready   (ready1),
        .x       (x1),
        .x_valid (xv1),
        .done    (done1),
        .ovr     (ovr1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: a word becomes a queue of bits; one bit leaves per cycle.
    initial begin
        forever begin
            bit rdy;
            @(posedge clk);
            cyc_n++;
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    mq[i].delete();
                    mx[i] = 1'b0;
                    mv[i] = 1'b0;
                    md[i] = 1'b0;
                    mo[i] = 1'b0;
                end else begin
                    rdy   = !mv[i] || (mq[i].size() == 0);
                    mo[i] = load && !rdy;
                    if (load && rdy) begin
                        mq[i].delete();
                        for (int b = 0; b < 8; b++)
                            mq[i].push_back(i == 0 ? din[7-b] : din[b]);
                    end
                    if (mq[i].size() > 0) begin
                        mx[i] = mq[i].pop_front();
                        mv[i] = 1'b1;
                    end else begin
                        mx[i] = 1'b0;
                        mv[i] = 1'b0;
                    end
                    md[i] = mv[i] && (mq[i].size() == 0);
                end
                mr[i] = !mv[i] || (mq[i].size() == 0);
            end
            if (rst) armed = 1'b1;
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("msb_x",     {31'd0, x0},     {31'd0, mx[0]});
                chk("msb_valid", {31'd0, xv0},    {31'd0, mv[0]});
                chk("msb_done",  {31'd0, done0},  {31'd0, md[0]});
                chk("msb_ovr",   {31'd0, ovr0},   {31'd0, mo[0]});
                chk("msb_ready", {31'd0, ready0}, {31'd0, mr[0]});
                chk("lsb_x",     {31'd0, x1},     {31'd0, mx[1]});
                chk("lsb_valid", {31'd0, xv1},    {31'd0, mv[1]});
                chk("lsb_done",  {31'd0, done1},  {31'd0, md[1]});
                chk("lsb_ovr",   {31'd0, ovr1},   {31'd0, mo[1]});
                chk("lsb_ready", {31'd0, ready1}, {31'd0, mr[1]});
                if (xv0) cap[0].push_back(x0);
                if (xv1) cap[1].push_back(x1);
                if (done0) dq.push_back(cyc_n);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_cap();
        cap[0].delete();
        cap[1].delete();
        dq.delete();
    endtask

    task automatic check_seq(input string name, input int inst,
                             input logic [15:0] exp, input int n);
        chk({name, "_len"}, cap[inst].size(), n);
        for (int i = 0; i < n && i < cap[inst].size(); i++)
            chk(name, {31'd0, cap[inst][i]}, {31'd0, exp[n-1-i]});
    endtask

    initial begin
        int base;
        rst  = 1'b1;
        load = 1'b1;
        din  = 8'hFF;

        // Reset held with a pending load.
        cyc();
        cyc();
        chk("rst_x",     {31'd0, x0},     32'd0);
        chk("rst_valid", {31'd0, xv0},    32'd0);
        chk("rst_done",  {31'd0, done0},  32'd0);
        chk("rst_ovr",   {31'd0, ovr0},   32'd0);
        chk("rst_ready", {31'd0, ready0}, 32'd1);
        rst  = 1'b0;
        load = 1'b0;
        clr_cap();
        repeat (3) cyc();
        chk("rst_no_bits", cap[0].size(), 0);

        // Single word, MSB first.
        clr_cap();
        load = 1'b1;
        din  = 8'hC6;
        base = cyc_n;
        cyc();
        load = 1'b0;
        din  = 8'h3C;
        repeat (7) cyc();
        chk("w1_done_c8",  {31'd0, done0},  32'd1);
        chk("w1_ready_c8", {31'd0, ready0}, 32'd1);
        cyc();
        chk("w1_valid_c9", {31'd0, xv0}, 32'd0);
        check_seq("w1_bits", 0, 16'h00C6, 8);
        chk("w1_ndone", dq.size(), 1);
        if (dq.size() > 0) chk("w1_done_at", dq[0], base + 8);

        // Back-to-back words, no gap.
        clr_cap();
        load = 1'b1;
        din  = 8'hB0;
        base = cyc_n;
        cyc();
        load = 1'b0;
        repeat (7) cyc();
        load = 1'b1;
        din  = 8'h0F;
        cyc();
        load = 1'b0;
        repeat (8) cyc();
        check_seq("b2b_bits", 0, 16'hB00F, 16);
        chk("b2b_ndone", dq.size(), 2);
        if (dq.size() > 1) begin
            chk("b2b_done0", dq[0], base + 8);
            chk("b2b_done1", dq[1], base + 16);
        end

        // Overrun while busy.
        clr_cap();
        load = 1'b1;
        din  = 8'hAA;
        cyc();
        load = 1'b0;
        cyc();
        cyc();
        load = 1'b1;
        din  = 8'h55;
        cyc();
        load = 1'b0;
        chk("ovr_c4", {31'd0, ovr0}, 32'd1);
        cyc();
        chk("ovr_c5", {31'd0, ovr0}, 32'd0);
        repeat (4) cyc();
        check_seq("ovr_bits", 0, 16'h00AA, 8);

        // Reset mid-word.
        clr_cap();
        load = 1'b1;
        din  = 8'hFF;
        cyc();
        load = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_x",     {31'd0, x0},     32'd0);
        chk("mid_valid", {31'd0, xv0},    32'd0);
        chk("mid_ready", {31'd0, ready0}, 32'd1);
        chk("mid_ndone", dq.size(), 0);
        clr_cap();
        cyc();
        load = 1'b1;
        din  = 8'h80;
        cyc();
        load = 1'b0;
        repeat (8) cyc();
        check_seq("mid_bits", 0, 16'h0080, 8);

        // LSB-first ordering.
        clr_cap();
        load = 1'b1;
        din  = 8'h06;
        cyc();
        load = 1'b0;
        repeat (8) cyc();
        check_seq("lsb_bits", 1, 16'h0060, 8);

        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
